// File: rtl/csr_file.sv
// Machine-mode CSR file and trap unit for the RV32I pipeline.
// It supplies CSR read data, performs CSR writes, handles ECALL/MRET redirects and runs the 64-bit counters.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_src,
  input  logic        exception,
  input  logic [31:0] exception_cause,
  input  logic [31:0] exception_pc,
  input  logic        is_mret,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        irq_enable
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  logic [31:0] mstatus_val;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        trap_take;
  logic        mret_take;
  logic        csr_wr;

  // MPP is hardwired to machine mode; only MIE and MPIE hold state.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

  assign trap_take = valid & exception;
  assign mret_take = valid & is_mret & ~exception;
  assign csr_wr    = valid & csr_write & ~exception & ~is_mret;

  always_comb begin
    old_val = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS:   old_val = mstatus_val;
      ADDR_MISA:      old_val = MISA_VALUE;
      ADDR_MIE:       old_val = mie_q;
      ADDR_MTVEC:     old_val = mtvec_q;
      ADDR_MSCRATCH:  old_val = mscratch_q;
      ADDR_MEPC:      old_val = mepc_q;
      ADDR_MCAUSE:    old_val = mcause_q;
      ADDR_MTVAL:     old_val = mtval_q;
      ADDR_MCYCLE:    old_val = mcycle_q[31:0];
      ADDR_MCYCLEH:   old_val = mcycle_q[63:32];
      ADDR_MINSTRET:  old_val = minstret_q[31:0];
      ADDR_MINSTRETH: old_val = minstret_q[63:32];
      ADDR_MHARTID:   old_val = HART_ID;
      default:        old_val = 32'h0;
    endcase
  end

  // Immediate and register forms share csr_op[1:0]; the operand is already selected upstream.
  always_comb begin
    new_val = old_val;
    case (csr_op[1:0])
      2'b01:   new_val = csr_src;
      2'b10:   new_val = old_val | csr_src;
      2'b11:   new_val = old_val & ~csr_src;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    csr_rdata   = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    if (rstn) begin
      if (csr_read) csr_rdata = old_val;
      if (trap_take) begin
        redirect    = 1'b1;
        redirect_pc = mtvec_q;
      end else if (mret_take) begin
        redirect    = 1'b1;
        redirect_pc = mepc_q;
      end
    end
  end

  assign irq_enable = mstatus_mie;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= 32'h0;
      mtvec_q      <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q   <= 32'h0;
      mepc_q       <= 32'h0;
      mcause_q     <= 32'h0;
      mtval_q      <= 32'h0;
    end else if (trap_take) begin
      mepc_q       <= {exception_pc[31:2], 2'b00};
      mcause_q     <= exception_cause;
      mtval_q      <= 32'h0;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_take) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie  <= new_val[3];
          mstatus_mpie <= new_val[7];
        end
        ADDR_MIE:      mie_q      <= new_val;
        ADDR_MTVEC:    mtvec_q    <= {new_val[31:2], 2'b00};
        ADDR_MSCRATCH: mscratch_q <= new_val;
        ADDR_MEPC:     mepc_q     <= {new_val[31:2], 2'b00};
        ADDR_MCAUSE:   mcause_q   <= new_val;
        ADDR_MTVAL:    mtval_q    <= new_val;
        default:       ;
      endcase
    end
  end

  // A write to either counter half replaces it and skips that cycle's increment, with no carry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (csr_wr && csr_addr == ADDR_MCYCLE)
        mcycle_q[31:0] <= new_val;
      else if (csr_wr && csr_addr == ADDR_MCYCLEH)
        mcycle_q[63:32] <= new_val;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (csr_wr && csr_addr == ADDR_MINSTRET)
        minstret_q[31:0] <= new_val;
      else if (csr_wr && csr_addr == ADDR_MINSTRETH)
        minstret_q[63:32] <= new_val;
      else if (valid && retire)
        minstret_q <= minstret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: directed vectors push hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_csr_file;

  logic        clk;
  logic        rstn;
  logic        valid;
  logic        csr_read;
  logic        csr_write;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic        exception;
  logic [31:0] exception_cause;
  logic [31:0] exception_pc;
  logic        is_mret;
  logic        retire;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq_enable;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  csr_file dut (
    .clk(clk),
    .rstn(rstn),
    .valid(valid),
    .csr_read(csr_read),
    .csr_write(csr_write),
    .csr_op(csr_op),
    .csr_addr(csr_addr),
    .csr_src(csr_src),
    .exception(exception),
    .exception_cause(exception_cause),
    .exception_pc(exception_pc),
    .is_mret(is_mret),
    .retire(retire),
    .csr_rdata(csr_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .irq_enable(irq_enable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input string field,
                              input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, actual, expected);
    end
  endtask

  // Monitor: one expectation is consumed per cycle in which the stimulus queued one.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output(e.name, "rdata", csr_rdata, e.rdata);
      check_output(e.name, "redirect", {31'b0, redirect}, {31'b0, e.redir});
      check_output(e.name, "redirect_pc", redirect_pc, e.rpc);
      check_output(e.name, "irq_enable", {31'b0, irq_enable}, {31'b0, e.irq});
    end
  end

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] op,
                       input logic [11:0] addr, input logic [31:0] src, input logic exc,
                       input logic [31:0] cause, input logic [31:0] epc,
                       input logic mret, input logic ret);
    valid           = v;
    csr_read        = rd;
    csr_write       = wr;
    csr_op          = op;
    csr_addr        = addr;
    csr_src         = src;
    exception       = exc;
    exception_cause = cause;
    exception_pc    = epc;
    is_mret         = mret;
    retire          = ret;
  endtask

  task automatic apply_stimulus(input string name, input logic chk, input logic [31:0] e_rdata,
                                input logic e_redir, input logic [31:0] e_rpc, input logic e_irq);
    exp_t e;
    if (chk) begin
      e.name  = name;
      e.rdata = e_rdata;
      e.redir = e_redir;
      e.rpc   = e_rpc;
      e.irq   = e_irq;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input string name, input logic [11:0] addr,
                          input logic [31:0] exp_val, input logic exp_irq);
    drive(1'b1, 1'b1, 1'b0, 3'b000, addr, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(name, 1'b1, exp_val, 1'b0, 32'h0, exp_irq);
  endtask

  task automatic write_csr(input string name, input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic [31:0] exp_old, input logic exp_irq);
    drive(1'b1, 1'b1, 1'b1, op, addr, src, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(name, 1'b1, exp_old, 1'b0, 32'h0, exp_irq);
  endtask

  task automatic idle(input logic v, input logic ret);
    drive(v, 1'b0, 1'b0, 3'b000, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, ret);
    apply_stimulus("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Outputs stay quiet while reset is held, even with a live trap and read.
    drive(1'b1, 1'b1, 1'b0, 3'b000, 12'h300, 32'h0, 1'b1, 32'd11, 32'h100, 1'b0, 1'b0);
    apply_stimulus("in_reset", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    rstn = 1'b1;

    read_csr("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
    read_csr("rst_mtvec",   12'h305, 32'h0000_0000, 1'b0);
    read_csr("rst_mhartid", 12'hF14, 32'h0000_0000, 1'b0);
    read_csr("unimpl_7c0",  12'h7C0, 32'h0000_0000, 1'b0);
    read_csr("misa",        12'h301, 32'h4000_0100, 1'b0);

    write_csr("rw_mscratch", 3'b001, 12'h340, 32'hA5A5_0000, 32'h0, 1'b0);
    read_csr ("rd_mscratch1", 12'h340, 32'hA5A5_0000, 1'b0);
    write_csr("rs_mscratch", 3'b010, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0);
    read_csr ("rd_mscratch2", 12'h340, 32'hA5A5_00FF, 1'b0);
    write_csr("rc_mscratch", 3'b011, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b0);
    read_csr ("rd_mscratch3", 12'h340, 32'h00A5_00FF, 1'b0);

    write_csr("ro_misa_wr", 3'b001, 12'h301, 32'hFFFF_FFFF, 32'h4000_0100, 1'b0);
    read_csr ("ro_misa_rd", 12'h301, 32'h4000_0100, 1'b0);
    write_csr("unimpl_wr", 3'b001, 12'h7C0, 32'h1234_5678, 32'h0, 1'b0);
    read_csr ("unimpl_rd", 12'h7C0, 32'h0, 1'b0);

    // Write without read: rdata must stay 0.
    drive(1'b1, 1'b0, 1'b1, 3'b001, 12'h305, 32'h0000_0103, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    apply_stimulus("wr_mtvec_noread", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    read_csr ("rd_mtvec", 12'h305, 32'h0000_0100, 1'b0);
    write_csr("rw_mie", 3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
    read_csr ("rd_mie", 12'h304, 32'hFFFF_FFFF, 1'b0);
    write_csr("wr_mtval", 3'b001, 12'h343, 32'hDEAD_BEEF, 32'h0, 1'b0);
    write_csr("rsi_mstatus", 3'b110, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0);
    read_csr ("rd_mstatus_mie", 12'h300, 32'h0000_1808, 1'b1);

    drive(1'b1, 1'b0, 1'b0, 3'b000, 12'h000, 32'h0, 1'b1, 32'd11, 32'h0000_2002, 1'b0, 1'b0);
    apply_stimulus("ecall", 1'b1, 32'h0, 1'b1, 32'h0000_0100, 1'b1);
    read_csr("ecall_mepc",    12'h341, 32'h0000_2000, 1'b0);
    read_csr("ecall_mcause",  12'h342, 32'd11, 1'b0);
    read_csr("ecall_mstatus", 12'h300, 32'h0000_1880, 1'b0);
    read_csr("ecall_mtval",   12'h343, 32'h0, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 3'b000, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    apply_stimulus("mret", 1'b1, 32'h0, 1'b1, 32'h0000_2000, 1'b0);
    read_csr("mret_mstatus", 12'h300, 32'h0000_1888, 1'b1);

    // Exception beats MRET and the CSR write in the same cycle.
    drive(1'b1, 1'b1, 1'b1, 3'b001, 12'h340, 32'h0000_1234, 1'b1, 32'd2, 32'h0000_3000, 1'b1, 1'b0);
    apply_stimulus("prio_trap", 1'b1, 32'h00A5_00FF, 1'b1, 32'h0000_0100, 1'b1);
    read_csr("prio_mscratch", 12'h340, 32'h00A5_00FF, 1'b0);
    read_csr("prio_mepc",     12'h341, 32'h0000_3000, 1'b0);
    read_csr("prio_mcause",   12'h342, 32'd2, 1'b0);
    read_csr("prio_mstatus",  12'h300, 32'h0000_1880, 1'b0);

    drive(1'b0, 1'b1, 1'b1, 3'b001, 12'h340, 32'h0000_1234, 1'b1, 32'd7, 32'h0000_5000, 1'b1, 1'b0);
    apply_stimulus("novalid", 1'b1, 32'h00A5_00FF, 1'b0, 32'h0, 1'b0);
    read_csr("novalid_mscratch", 12'h340, 32'h00A5_00FF, 1'b0);
    read_csr("novalid_mepc",     12'h341, 32'h0000_3000, 1'b0);
    read_csr("novalid_mcause",   12'h342, 32'd2, 1'b0);

    write_csr("wr_mepc", 3'b001, 12'h341, 32'h0000_4003, 32'h0000_3000, 1'b0);
    read_csr ("rd_mepc", 12'h341, 32'h0000_4000, 1'b0);

    drive(1'b1, 1'b0, 1'b1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    apply_stimulus("wr_mcycle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 12'hB80, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    apply_stimulus("wr_mcycleh", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 1'b0);
    read_csr("mcycle_carry_hi", 12'hB80, 32'h0000_0001, 1'b0);
    read_csr("mcycle_carry_lo", 12'hB00, 32'h0000_0001, 1'b0);

    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    read_csr("minstret",  12'hB02, 32'd3, 1'b0);
    read_csr("minstreth", 12'hB82, 32'd0, 1'b0);

    // Asynchronous reset mid-run, with a live trap request that must not redirect.
    rstn = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b000, 12'h340, 32'h0, 1'b1, 32'd11, 32'h100, 1'b0, 1'b1);
    apply_stimulus("mid_reset", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    rstn = 1'b1;
    read_csr("post_rst_mcycle",   12'hB00, 32'h0, 1'b0);
    read_csr("post_rst_mcycleh",  12'hB80, 32'h0, 1'b0);
    read_csr("post_rst_minstret", 12'hB02, 32'h0, 1'b0);
    read_csr("post_rst_mscratch", 12'h340, 32'h0, 1'b0);
    read_csr("post_rst_mie",      12'h304, 32'h0, 1'b0);
    read_csr("post_rst_mepc",     12'h341, 32'h0, 1'b0);
    read_csr("post_rst_mtvec",    12'h305, 32'h0, 1'b0);
    read_csr("post_rst_mstatus",  12'h300, 32'h0000_1800, 1'b0);

    idle(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
